idiv_queued: RTL and testbench

- Self-contained iterative integer divide/remainder unit for the vanilla core. It implements the RISC-V DIV/DIVU/REM/REMU semantics.
- Successor to the current divider wrapper. What it adds:
  - width is parametrised;
  - divide-by-zero and signed-overflow cases finish early, in one cycle;
  - a parametrised in-order result queue, so the core can keep issuing while earlier results wait on writeback arbitration.
- Sits between the EXE-stage issue logic and the writeback arbiter.

---
 rtl/idiv_queued_pkg.sv | 29 ++
 rtl/bsg_fifo_1r1w_small.sv | 60 ++++++
 rtl/idiv_queued_core.sv | 120 ++++++++++++
 rtl/idiv_queued.sv | 67 ++++++
 tb/tb_idiv_queued.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/idiv_queued_pkg.sv
// Shared types for the iterative integer divide unit: operation codes, FSM
// states and the default datapath/tag widths of the vanilla core.
package idiv_queued_pkg;

  localparam int reg_data_width_gp = 32;
  localparam int reg_addr_width_gp = 5;

  typedef enum logic [1:0] {
    eDIV  = 2'b00,
    eDIVU = 2'b01,
    eREM  = 2'b10,
    eREMU = 2'b11
  } idiv_op_e;

  typedef enum logic [1:0] {
    eIDIV_IDLE,
    eIDIV_CALC,
    eIDIV_FIX
  } idiv_state_e;

  function automatic logic op_is_signed(idiv_op_e op);
    return (op == eDIV) || (op == eREM);
  endfunction

  function automatic logic op_is_rem(idiv_op_e op);
    return (op == eREM) || (op == eREMU);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with one write and one read port.
// Head is shown combinationally; yumi_i pops it.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign v_o     = (count_r != '0);
  assign ready_o = (count_r < cnt_w_lp'(els_p));
  assign deq     = yumi_i & v_o;
  // A full queue may still accept when the head leaves in the same cycle.
  assign enq     = v_i & (ready_o | deq);
  assign data_o  = mem_r[rd_ptr_r];

  // NOTE: storage has no reset; a slot is only read after it has been written,
  // and leaving it out keeps the array as plain memory.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= bump(wr_ptr_r);
      if (deq) rd_ptr_r <= bump(rd_ptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/idiv_queued_core.sv
// Restoring radix-2 divider FSM and datapath (RISC-V DIV/DIVU/REM/REMU).
// Emits a one-cycle {rd, result} enqueue pulse from the FIX state.
module idiv_queued_core
  import idiv_queued_pkg::*;
#(
  parameter int data_width_p     = reg_data_width_gp,
  parameter int reg_addr_width_p = reg_addr_width_gp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 v_i,
  input  logic [data_width_p-1:0]              rs1_i,
  input  logic [data_width_p-1:0]              rs2_i,
  input  logic [reg_addr_width_p-1:0]          rd_i,
  input  idiv_op_e                             op_i,
  output logic                                 ready_and_o,
  input  logic                                 enq_ready_i,
  output logic                                 enq_v_o,
  output logic [reg_addr_width_p+data_width_p-1:0] enq_data_o
);

  localparam int w_lp     = data_width_p;
  localparam int cnt_w_lp = $clog2(data_width_p);
  localparam logic [w_lp-1:0]     min_lp      = {1'b1, {(w_lp-1){1'b0}}};
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(data_width_p - 1);

  idiv_state_e state_r, state_n;

  logic                        signed_op, div_zero, overflow, accept;
  logic [w_lp-1:0]             rs1_mag, rs2_mag;
  logic [w_lp:0]               shifted, trial;
  logic                        q_bit;
  logic [w_lp-1:0]             quot_r, rem_r, divisor_r;
  logic [cnt_w_lp-1:0]         cnt_r;
  logic [reg_addr_width_p-1:0] rd_r;
  logic                        is_rem_r, neg_q_r, neg_r_r;
  logic [w_lp-1:0]             fix_q, fix_r;

  assign signed_op = op_is_signed(op_i);
  assign div_zero  = (rs2_i == '0);
  assign overflow  = signed_op && (rs1_i == min_lp) && (rs2_i == {w_lp{1'b1}});
  assign rs1_mag   = (signed_op && rs1_i[w_lp-1]) ? -rs1_i : rs1_i;
  assign rs2_mag   = (signed_op && rs2_i[w_lp-1]) ? -rs2_i : rs2_i;

  assign ready_and_o = reset_n_i && (state_r == eIDIV_IDLE) && enq_ready_i;
  assign accept      = v_i && ready_and_o;

  // Trial subtract is one bit wider than the remainder so its MSB is the borrow.
  assign shifted = {rem_r, quot_r[w_lp-1]};
  assign trial   = shifted - {1'b0, divisor_r};
  assign q_bit   = ~trial[w_lp];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eIDIV_IDLE;
    else            state_r <= state_n;
  end

  // NOTE: next-state gets a default first so no path through the case leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state_r;
    case (state_r)
      eIDIV_IDLE: if (accept) state_n = (div_zero || overflow) ? eIDIV_FIX : eIDIV_CALC;
      eIDIV_CALC: if (cnt_r == last_cnt_lp) state_n = eIDIV_FIX;
      eIDIV_FIX:  state_n = eIDIV_IDLE;
      default:    state_n = eIDIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      quot_r    <= '0;
      rem_r     <= '0;
      divisor_r <= '0;
      cnt_r     <= '0;
      rd_r      <= '0;
      is_rem_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else begin
      case (state_r)
        eIDIV_IDLE: if (accept) begin
          rd_r     <= rd_i;
          is_rem_r <= op_is_rem(op_i);
          cnt_r    <= '0;
          if (div_zero) begin
            quot_r  <= '1;
            rem_r   <= rs1_i;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
          end else if (overflow) begin
            quot_r  <= min_lp;
            rem_r   <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
          end else begin
            quot_r    <= rs1_mag;
            divisor_r <= rs2_mag;
            rem_r     <= '0;
            neg_q_r   <= signed_op && (rs1_i[w_lp-1] ^ rs2_i[w_lp-1]);
            neg_r_r   <= signed_op && rs1_i[w_lp-1];
          end
        end
        eIDIV_CALC: begin
          // The dividend register shifts out MSB-first and fills with quotient bits.
          rem_r  <= q_bit ? trial[w_lp-1:0] : shifted[w_lp-1:0];
          quot_r <= {quot_r[w_lp-2:0], q_bit};
          cnt_r  <= cnt_r + cnt_w_lp'(1);
        end
        default: ;
      endcase
    end
  end

  assign fix_q      = neg_q_r ? -quot_r : quot_r;
  assign fix_r      = neg_r_r ? -rem_r  : rem_r;
  assign enq_v_o    = (state_r == eIDIV_FIX);
  assign enq_data_o = {rd_r, is_rem_r ? fix_r : fix_q};

endmodule

// File: rtl/idiv_queued.sv
// Iterative divide/remainder unit with an in-order result queue, placed
// between EXE-stage issue and the writeback arbiter.
module idiv_queued
  import idiv_queued_pkg::*;
#(
  parameter int data_width_p     = reg_data_width_gp,
  parameter int reg_addr_width_p = reg_addr_width_gp,
  parameter int out_fifo_els_p   = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  input  logic [data_width_p-1:0]     rs1_i,
  input  logic [data_width_p-1:0]     rs2_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  input  idiv_op_e                    op_i,
  output logic                        ready_and_o,
  output logic                        v_o,
  output logic [reg_addr_width_p-1:0] rd_o,
  output logic [data_width_p-1:0]     result_o,
  input  logic                        yumi_i
);

  localparam int entry_w_lp = reg_addr_width_p + data_width_p;

  logic                  fifo_ready, enq_v;
  logic [entry_w_lp-1:0] enq_data, head_data;

  idiv_queued_core #(
    .data_width_p     (data_width_p),
    .reg_addr_width_p (reg_addr_width_p)
  ) core (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rd_i        (rd_i),
    .op_i        (op_i),
    .ready_and_o (ready_and_o),
    .enq_ready_i (fifo_ready),
    .enq_v_o     (enq_v),
    .enq_data_o  (enq_data)
  );

  bsg_fifo_1r1w_small #(
    .width_p (entry_w_lp),
    .els_p   (out_fifo_els_p)
  ) out_fifo (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .v_i     (enq_v),
    .ready_o (fifo_ready),
    .data_i  (enq_data),
    .v_o     (v_o),
    .data_o  (head_data),
    .yumi_i  (yumi_i)
  );

  // Head fields are forced to zero when empty so reset shows clean outputs.
  assign rd_o     = v_o ? head_data[entry_w_lp-1:data_width_p] : '0;
  assign result_o = v_o ? head_data[data_width_p-1:0] : '0;

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);

endmodule

// File: tb/tb_idiv_queued.sv
// Self-checking bench for idiv_queued: directed corner cases, backpressure,
// asynchronous abort and randomized traffic against an arithmetic model.
module tb_idiv_queued;
  import idiv_queued_pkg::*;

  localparam logic [31:0] MIN  = 32'h8000_0000;
  localparam logic [31:0] MAX  = 32'h7fff_ffff;
  localparam logic [31:0] ONES = 32'hffff_ffff;
  localparam int          N_RAND = 150;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic [4:0]  rd_i = '0;
  idiv_op_e    op_i = eDIV;
  logic        ready_and_o, v_o, yumi_i = 1'b0;
  logic [4:0]  rd_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];

  idiv_queued dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rd_i        (rd_i),
    .op_i        (op_i),
    .ready_and_o (ready_and_o),
    .v_o         (v_o),
    .rd_o        (rd_o),
    .result_o    (result_o),
    .yumi_i      (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(idiv_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      eDIVU: return (b == 0) ? ONES : a / b;
      eREMU: return (b == 0) ? a : a % b;
      eDIV: begin
        if (b == 0) return ONES;
        if (a == MIN && b == ONES) return MIN;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == MIN && b == ONES) return 32'd0;
        return sa % sb;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return MIN;
      3:       return MAX;
      4:       return ONES;
      5:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drives a request from just after a rising edge and returns one cycle after the handshake.
  task automatic send(input idiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int budget = 0;
    @(posedge clk_i);
    #1;
    op_i  = op;
    rs1_i = a;
    rs2_i = b;
    rd_i  = rd;
    v_i   = 1'b1;
    @(negedge clk_i);
    while (!ready_and_o && budget < 400) begin
      @(negedge clk_i);
      budget++;
    end
    if (budget >= 400) check("send_ready_timeout", {63'd0, ready_and_o}, 64'd1);
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!v_o && lat < 200);
  endtask

  task automatic pop();
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
  endtask

  task automatic run_directed(input string tag, input idiv_op_e op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] exp, input int exp_lat);
    int lat;
    send(op, a, b, rd);
    wait_result(lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, {32'd0, result_o}, {32'd0, exp});
    check({tag, "_rd"}, {59'd0, rd_o}, {59'd0, rd});
    pop();
  endtask

  initial begin
    int lat, hits;

    repeat (3) @(negedge clk_i);
    check("reset_v_o", {63'd0, v_o}, 64'd0);
    check("reset_ready", {63'd0, ready_and_o}, 64'd0);
    check("reset_rd_o", {59'd0, rd_o}, 64'd0);
    check("reset_result", {32'd0, result_o}, 64'd0);
    #2 reset_n_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_ready", {63'd0, ready_and_o}, 64'd1);

    run_directed("divu_100_7", eDIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    run_directed("remu_100_7", eREMU, 32'd100, 32'd7, 5'd4, 32'd2, 34);
    run_directed("div_m7_2",   eDIV,  32'hffff_fff9, 32'd2, 5'd5, 32'hffff_fffd, 34);
    run_directed("rem_m7_2",   eREM,  32'hffff_fff9, 32'd2, 5'd6, 32'hffff_ffff, 34);
    run_directed("div_7_m2",   eDIV,  32'd7, 32'hffff_fffe, 5'd7, 32'hffff_fffd, 34);
    run_directed("rem_7_m2",   eREM,  32'd7, 32'hffff_fffe, 5'd8, 32'd1, 34);
    run_directed("div_5_0",    eDIV,  32'd5, 32'd0, 5'd9, 32'hffff_ffff, 2);
    run_directed("remu_5_0",   eREMU, 32'd5, 32'd0, 5'd10, 32'd5, 2);
    run_directed("rem_m7_0",   eREM,  32'hffff_fff9, 32'd0, 5'd11, 32'hffff_fff9, 2);
    run_directed("div_ovf",    eDIV,  MIN, ONES, 5'd12, MIN, 2);
    run_directed("rem_ovf",    eREM,  MIN, ONES, 5'd13, 32'd0, 2);

    // Backpressure: two results fill the queue, the third request must stall.
    send(eDIVU, 32'd100, 32'd7, 5'd1);
    send(eREMU, 32'd100, 32'd7, 5'd2);
    op_i  = eDIV;
    rs1_i = 32'hffff_fff9;
    rs2_i = 32'd2;
    rd_i  = 5'd4;
    v_i   = 1'b1;
    hits  = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (ready_and_o) hits++;
    end
    check("full_ready_seen", 64'(hits), 64'd0);
    check("full_head_v", {63'd0, v_o}, 64'd1);
    check("full_head_result", {32'd0, result_o}, 64'd14);
    check("full_head_rd", {59'd0, rd_o}, 64'd1);
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_pop", {63'd0, ready_and_o}, 64'd1);
    check("second_result", {32'd0, result_o}, 64'd2);
    check("second_rd", {59'd0, rd_o}, 64'd2);
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    v_i    = 1'b0;
    wait_result(lat);
    check("third_result", {32'd0, result_o}, 64'hffff_fffd);
    check("third_rd", {59'd0, rd_o}, 64'd4);
    pop();

    // Asynchronous abort with one result queued and one op in CALC.
    send(eDIVU, 32'd50, 32'd5, 5'd7);
    wait_result(lat);
    check("abort_queued_v", {63'd0, v_o}, 64'd1);
    send(eDIV, 32'd1000, 32'd3, 5'd8);
    repeat (9) @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check("abort_v_o", {63'd0, v_o}, 64'd0);
    check("abort_ready", {63'd0, ready_and_o}, 64'd0);
    check("abort_result", {32'd0, result_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    @(negedge clk_i);
    check("abort_release_ready", {63'd0, ready_and_o}, 64'd1);
    hits = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (v_o) hits++;
    end
    check("abort_no_result", 64'(hits), 64'd0);

    // Randomized traffic with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          idiv_op_e    op;
          logic [31:0] a, b;
          logic [4:0]  rd;
          op = idiv_op_e'(2'($urandom_range(0, 3)));
          a  = pick_operand();
          b  = pick_operand();
          rd = 5'($urandom_range(0, 31));
          exp_q.push_back({rd, ref_model(op, a, b)});
          send(op, a, b, rd);
          repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < N_RAND && cyc < 20000) begin
          @(negedge clk_i);
          cyc++;
          yumi_i = 1'b0;
          if (v_o && $urandom_range(0, 2) != 0) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", {63'd0, v_o}, 64'd0);
            end else begin
              check("rand_result", {27'd0, rd_o, result_o}, {27'd0, exp_q.pop_front()});
              yumi_i = 1'b1;
              got++;
            end
          end
        end
        @(posedge clk_i);
        #1;
        yumi_i = 1'b0;
        check("rand_count", 64'(got), 64'(N_RAND));
      end
    join
    check("rand_leftover", 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    check("final_empty", {63'd0, v_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
